inv_sub_bytes: RTL and testbench
================================

INV_SUB_BYTES -- requirements
Module: inv_sub_bytes

Interface
REQ-001 The block SHALL have one clock, clk_in; reset rst_in SHALL be asynchronous and active-high.
REQ-002 The block SHALL have parameter ROM_INIT_FILE, default "inv_byte_sub_table.mem", giving the inverse S-box init file used when INV_SBOX_BRAM_EN is defined.
REQ-003 clk_in  input  1  clock.
REQ-004 rst_in  input  1  asynchronous active-high reset.
REQ-005 new_block_in  input  1  block_in is valid this cycle; start request.
REQ-006 block_in  input  [15:0][7:0]  block to inverse-substitute, byte i = block_in[i].
REQ-007 ready_out  output  1  high only in IDLE; block accepts a request.
REQ-008 inv_subbed_block_out  output  [15:0][7:0]  result, held until the next result or reset.
REQ-009 valid_out  output  1  one-cycle pulse: inv_subbed_block_out has just been updated.

Function
REQ-010 The block SHALL compute out[i] = InvSbox(in[i]) for i = 0..15 per FIPS-197 Fig. 14, with no byte reordering.
REQ-011 The FSM SHALL have states IDLE, ISSUE, DRAIN and OUTPUT.
REQ-012 In IDLE with new_block_in=1, the block SHALL capture block_in into an internal register, clear issue and capture indices to 0, and go to ISSUE.
REQ-013 new_block_in SHALL be ignored in every state other than IDLE, with no effect on the block in flight.
REQ-014 In ISSUE, the block SHALL present the lookup address for saved byte issue_idx each cycle, one byte per cycle with no stall cycles, and increment issue_idx.
REQ-015 After byte 15 is issued, the FSM SHALL go to DRAIN.
REQ-016 A lookup SHALL return L cycles after issue: L=2 with INV_SBOX_BRAM_EN, L=1 without.
REQ-017 Each returned byte SHALL be written to internal result byte capture_idx, then capture_idx SHALL increment; a per-stage valid shift register of depth L SHALL track which cycles carry returns.
REQ-018 When capture of byte 15 completes, the FSM SHALL copy the internal result to inv_subbed_block_out, assert valid_out for exactly one cycle in OUTPUT, then return to IDLE.
REQ-019 valid_out SHALL first be high exactly 16+L+1 rising edges after the edge that sampled new_block_in (19 with BRAM, 18 without).
REQ-020 The earliest next accepted request SHALL be on the edge after valid_out deasserts, since ready_out is high again in IDLE.
REQ-021 Index counters SHALL be 5 bits wide, compared against 16, and SHALL never wrap inside one block.
REQ-022 Address SHALL equal the byte value zero-extended to 8 bits, giving ROM depth 256.

Reset
REQ-023 While rst_in is high, at any time including mid-block, the block SHALL set the state to IDLE, valid_out=0, inv_subbed_block_out=0, indices=0, and the pipeline valid bits=0.
REQ-024 During reset, ready_out SHALL be 1.
REQ-025 An in-flight block SHALL be discarded on reset, with no valid_out pulse.
REQ-026 Saved block and internal result registers need not be reset.

Configuration
REQ-027 Macro INV_SBOX_BRAM_EN defined: lookup SHALL use xilinx_single_port_ram_read_first, HIGH_PERFORMANCE, 8x256, initialised from ROM_INIT_FILE (L=2).
REQ-028 INV_SBOX_BRAM_EN undefined: lookup SHALL use a constant case-table with a registered output (L=1), and ROM_INIT_FILE SHALL be unused.

Structure
REQ-029 Shared package aes_pkg SHALL hold AES_BLOCK_BYTES=16, the block typedef ([15:0][7:0]), and the inv_sub_bytes state enum typedef.
REQ-030 Sub-module inv_sbox_rom SHALL encapsulate the lookup (addr in, byte out, latency L per INV_SBOX_BRAM_EN); inv_sub_bytes instantiates it once.

Verification
REQ-031 Block of all 0x63 -> inv_subbed_block_out all 0x00; valid_out pulses once at edge 16+L+1.
REQ-032 block_in[i]=i (0x00..0x0f) -> out bytes 0x52,0x09,0x6a,0xd5,0x30,0x36,0xa5,0x38,0xbf,0x40,0xa3,0x9e,0x81,0xf3,0xd7,0xfb.
REQ-033 Bytes {0x16,0xff,0x7c,0x00} in positions 0..3, rest 0x63 -> {0xff,0x7d,0x01,0x52}, rest 0x00.
REQ-034 Round trip: 200 random blocks through sub_bytes then inv_sub_bytes -> output equals the original block.
REQ-035 new_block_in pulsed again at issue cycle 5 with a different block -> ignored; the first result only; ready_out low throughout.
REQ-036 rst_in asserted at issue cycle 8 -> no valid_out pulse, outputs 0; a new block after release -> correct result at nominal latency.

Source files
------------

// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES types and constants for inv_sub_bytes.
//               Lookup latency depends on macro INV_SBOX_BRAM_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    typedef logic [AES_BLOCK_BYTES-1:0][7:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } inv_sub_bytes_state_t;

`ifdef INV_SBOX_BRAM_EN
    localparam int INV_SBOX_LATENCY = 2;
`else
    localparam int INV_SBOX_LATENCY = 1;
`endif

endpackage

`default_nettype wire

// File: rtl/inv_sub_bytes_if.sv
// ============================================================================
// Module      : inv_sub_bytes_if
// Description : Request/result bundle between a requester and inv_sub_bytes.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface inv_sub_bytes_if;
    import aes_pkg::*;

    logic       new_block_in;
    aes_block_t block_in;
    logic       ready_out;
    aes_block_t inv_subbed_block_out;
    logic       valid_out;

    modport master (
        output new_block_in,
        output block_in,
        input  ready_out,
        input  inv_subbed_block_out,
        input  valid_out
    );

    modport slave (
        input  new_block_in,
        input  block_in,
        output ready_out,
        output inv_subbed_block_out,
        output valid_out
    );

endinterface

`default_nettype wire

// File: rtl/inv_sbox_rom.sv
// ============================================================================
// Module      : inv_sbox_rom
// Description : AES inverse S-box lookup. INV_SBOX_BRAM_EN selects a BRAM
//               (latency 2); otherwise a registered constant table (latency 1).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module inv_sbox_rom #(
    parameter string ROM_INIT_FILE = "inv_byte_sub_table.mem"
) (
    input  wire logic       clk_in,
    input  wire logic [7:0] addr,
    output logic      [7:0] data
);

`ifdef INV_SBOX_BRAM_EN
    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH       (8),
        .RAM_DEPTH       (256),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE"),
        .INIT_FILE       (ROM_INIT_FILE)
    ) u_bram (
        .addra  (addr),
        .dina   (8'h00),
        .clka   (clk_in),
        .wea    (1'b0),
        .ena    (1'b1),
        .rsta   (1'b0),
        .regcea (1'b1),
        .douta  (data)
    );
`else
    // Each row holds 16 entries, entry 0 in the most significant byte.
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [127:0] row;
        row = '0;
        case (a[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            4'hf: row = 128'h172b047eba77d626e169146355210c7d;
            default: row = '0;
        endcase
        return row[{~a[3:0], 3'b000} +: 8];
    endfunction

    always_ff @(posedge clk_in) begin
        data <= inv_sbox(addr);
    end
`endif

endmodule

`default_nettype wire

// File: rtl/inv_sub_bytes.sv
// ============================================================================
// Module      : inv_sub_bytes
// Description : AES InvSubBytes over a 16-byte block, one ROM lookup per cycle.
//               Macro INV_SBOX_BRAM_EN selects the BRAM-based lookup.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module inv_sub_bytes
    import aes_pkg::*;
#(
    parameter string ROM_INIT_FILE = "inv_byte_sub_table.mem"
) (
    input  wire logic      clk_in,
    input  wire logic      rst_in,
    inv_sub_bytes_if.slave bus
);

    localparam int         L         = INV_SBOX_LATENCY;
    localparam logic [4:0] LAST_IDX  = 5'(AES_BLOCK_BYTES - 1);
    localparam logic [4:0] NUM_BYTES = 5'(AES_BLOCK_BYTES);

    inv_sub_bytes_state_t state;
    inv_sub_bytes_state_t next_state;

    logic [4:0]   issue_idx;
    logic [4:0]   capture_idx;
    logic [L-1:0] lookup_vld;
    aes_block_t   saved_block;
    aes_block_t   result_block;
    aes_block_t   out_block;
    logic         valid_q;
    logic         ready;
    logic         accept;
    logic [7:0]   lookup_addr;
    logic [7:0]   lookup_data;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.new_block_in) begin
                    accept     = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_idx == LAST_IDX) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (capture_idx == NUM_BYTES) begin
                    next_state = OUTPUT;
                end
            end
            OUTPUT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // lookup_vld[L-1] marks the cycle in which the ROM output belongs to a byte.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            issue_idx   <= '0;
            capture_idx <= '0;
            lookup_vld  <= '0;
            out_block   <= '0;
            valid_q     <= 1'b0;
        end else begin
            lookup_vld <= (lookup_vld << 1) | L'(state == ISSUE);
            valid_q    <= (next_state == OUTPUT);
            if (accept) begin
                issue_idx   <= '0;
                capture_idx <= '0;
            end else begin
                if (state == ISSUE) begin
                    issue_idx <= issue_idx + 5'd1;
                end
                if (lookup_vld[L-1]) begin
                    capture_idx <= capture_idx + 5'd1;
                end
            end
            if (next_state == OUTPUT) begin
                out_block <= result_block;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (accept) begin
            saved_block <= bus.block_in;
        end
        if (lookup_vld[L-1]) begin
            result_block[capture_idx[3:0]] <= lookup_data;
        end
    end

    assign lookup_addr = saved_block[issue_idx[3:0]];

    inv_sbox_rom #(
        .ROM_INIT_FILE (ROM_INIT_FILE)
    ) u_inv_sbox_rom (
        .clk_in (clk_in),
        .addr   (lookup_addr),
        .data   (lookup_data)
    );

    assign bus.ready_out            = ready;
    assign bus.inv_subbed_block_out = out_block;
    assign bus.valid_out            = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_inv_sub_bytes.sv
// ============================================================================
// Module      : tb_inv_sub_bytes
// Description : Directed self-checking bench for inv_sub_bytes.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inv_sub_bytes;
    import aes_pkg::*;

`ifdef INV_SBOX_BRAM_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    localparam int LAT = 16 + L + 1;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [7:0] sbox_tbl [256];

    inv_sub_bytes_if bus ();

    inv_sub_bytes #(
        .ROM_INIT_FILE ("inv_byte_sub_table.mem")
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Forward S-box built from the GF(2^8) inverse and the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            if (a != 0) begin
                for (int b = 1; b < 256; b++) begin
                    if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
                end
            end
            sbox_tbl[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    // Called #1 after a rising edge; returns latency from the sampling edge.
    task automatic send_block(input aes_block_t blk, output int lat,
                              output aes_block_t res, output int pulses,
                              output int busy_ready);
        bus.block_in     = blk;
        bus.new_block_in = 1'b1;
        @(posedge clk);
        #1 bus.new_block_in = 1'b0;
        lat        = -1;
        pulses     = 0;
        busy_ready = 0;
        res        = '0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.valid_out) begin
                if (lat < 0) begin
                    lat = e;
                    res = bus.inv_subbed_block_out;
                end
                pulses++;
            end
            if ((lat < 0 || lat == e) && bus.ready_out) busy_ready++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.ready_out !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got %b expected 1", bus.ready_out);
        end
        n_cmp++;
        if (bus.valid_out !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.valid_out);
        end
        n_cmp++;
        if (bus.inv_subbed_block_out !== '0) begin
            n_bad++; $display("FAIL reset_out: got %h expected 0", bus.inv_subbed_block_out);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.ready_out !== 1'b1 || bus.valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got ready=%b valid=%b expected ready=1 valid=0",
                     bus.ready_out, bus.valid_out);
        end
    endtask

    task automatic test_all_63();
        aes_block_t blk;
        aes_block_t res;
        int lat, pulses, busy;
        for (int i = 0; i < 16; i++) blk[i] = 8'h63;
        send_block(blk, lat, res, pulses, busy);
        n_cmp++;
        if (res !== '0) begin
            n_bad++; $display("FAIL all63_result: got %h expected 0", res);
        end
        n_cmp++;
        if (lat !== LAT) begin
            n_bad++; $display("FAIL all63_latency: got %0d expected %0d", lat, LAT);
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++; $display("FAIL all63_pulses: got %0d expected 1", pulses);
        end
        n_cmp++;
        if (busy !== 0) begin
            n_bad++; $display("FAIL all63_ready_busy: got %0d cycles expected 0", busy);
        end
    endtask

    task automatic test_counting();
        aes_block_t blk;
        aes_block_t res;
        aes_block_t exp;
        int lat, pulses, busy;
        for (int i = 0; i < 16; i++) blk[i] = 8'(i);
        exp = 128'hfbd7f3819ea340bf38a53630d56a0952;
        send_block(blk, lat, res, pulses, busy);
        n_cmp++;
        if (res !== exp) begin
            n_bad++; $display("FAIL counting_result: got %h expected %h", res, exp);
        end
        n_cmp++;
        if (lat !== LAT) begin
            n_bad++; $display("FAIL counting_latency: got %0d expected %0d", lat, LAT);
        end
    endtask

    task automatic test_mixed();
        aes_block_t blk;
        aes_block_t res;
        aes_block_t exp;
        int lat, pulses, busy;
        blk = 128'h636363636363636363636363007cff16;
        exp = 128'h00000000000000000000000052017dff;
        send_block(blk, lat, res, pulses, busy);
        n_cmp++;
        if (res !== exp) begin
            n_bad++; $display("FAIL mixed_result: got %h expected %h", res, exp);
        end
    endtask

    task automatic test_ignore_new();
        aes_block_t exp;
        aes_block_t res;
        int lat, pulses, busy;
        exp = 128'h00000000000000000000000052017dff;
        lat = -1; pulses = 0; busy = 0; res = '0;
        bus.block_in     = 128'h636363636363636363636363007cff16;
        bus.new_block_in = 1'b1;
        // e counts edges; edge 1 samples the request, edge 6 begins issue cycle 5.
        for (int e = 1; e <= 50; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) bus.new_block_in = 1'b0;
            if (e == 6) begin
                bus.block_in     = 128'h0f0e0d0c0b0a09080706050403020100;
                bus.new_block_in = 1'b1;
            end
            if (e == 7) bus.new_block_in = 1'b0;
            if (bus.valid_out) begin
                if (lat < 0) begin
                    lat = e;
                    res = bus.inv_subbed_block_out;
                end
                pulses++;
            end
            if (e > 1 && (lat < 0 || lat == e) && bus.ready_out) busy++;
        end
        n_cmp++;
        if (res !== exp) begin
            n_bad++; $display("FAIL ignore_result: got %h expected %h", res, exp);
        end
        n_cmp++;
        if (lat !== LAT + 1) begin
            n_bad++; $display("FAIL ignore_latency: got %0d expected %0d", lat, LAT + 1);
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++; $display("FAIL ignore_pulses: got %0d expected 1", pulses);
        end
        n_cmp++;
        if (busy !== 0) begin
            n_bad++; $display("FAIL ignore_ready_busy: got %0d cycles expected 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        aes_block_t blk;
        aes_block_t res;
        aes_block_t exp;
        int lat, pulses, busy;
        bus.block_in     = 128'h0f0e0d0c0b0a09080706050403020100;
        bus.new_block_in = 1'b1;
        @(posedge clk);
        #1 bus.new_block_in = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        n_cmp++;
        if (bus.ready_out !== 1'b1 || bus.valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_async_ctrl: got ready=%b valid=%b expected ready=1 valid=0",
                     bus.ready_out, bus.valid_out);
        end
        n_cmp++;
        if (bus.inv_subbed_block_out !== '0) begin
            n_bad++; $display("FAIL midrst_async_out: got %h expected 0", bus.inv_subbed_block_out);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        pulses = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.valid_out) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || bus.inv_subbed_block_out !== '0) begin
            n_bad++;
            $display("FAIL midrst_discard: got pulses=%0d out=%h expected pulses=0 out=0",
                     pulses, bus.inv_subbed_block_out);
        end
        blk = 128'h636363636363636363636363007cff16;
        exp = 128'h00000000000000000000000052017dff;
        send_block(blk, lat, res, pulses, busy);
        n_cmp++;
        if (res !== exp || lat !== LAT) begin
            n_bad++;
            $display("FAIL midrst_recover: got %h lat %0d expected %h lat %0d", res, lat, exp, LAT);
        end
    endtask

    task automatic test_back_to_back();
        aes_block_t res1;
        aes_block_t res2;
        aes_block_t exp2;
        int v1, v2;
        v1 = -1; v2 = -1; res1 = 'x; res2 = 'x;
        exp2 = 128'hfbd7f3819ea340bf38a53630d56a0952;
        for (int i = 0; i < 16; i++) bus.block_in[i] = 8'h63;
        bus.new_block_in = 1'b1;
        // Request held high; edge 1 samples the first block.
        for (int e = 1; e <= 80; e++) begin
            @(posedge clk);
            #1;
            if (bus.valid_out) begin
                if (v1 < 0) begin
                    v1   = e;
                    res1 = bus.inv_subbed_block_out;
                    bus.block_in = 128'h0f0e0d0c0b0a09080706050403020100;
                end else if (v2 < 0 && e > v1) begin
                    v2   = e;
                    res2 = bus.inv_subbed_block_out;
                    bus.new_block_in = 1'b0;
                end
            end
        end
        bus.new_block_in = 1'b0;
        n_cmp++;
        if (res1 !== '0 || v1 !== LAT + 1) begin
            n_bad++;
            $display("FAIL b2b_first: got %h at edge %0d expected 0 at edge %0d", res1, v1, LAT + 1);
        end
        n_cmp++;
        if (res2 !== exp2) begin
            n_bad++; $display("FAIL b2b_second_result: got %h expected %h", res2, exp2);
        end
        n_cmp++;
        if (v2 - v1 !== LAT + 2) begin
            n_bad++; $display("FAIL b2b_spacing: got %0d expected %0d", v2 - v1, LAT + 2);
        end
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic test_round_trip();
        aes_block_t orig;
        aes_block_t fwd;
        aes_block_t res;
        int lat, pulses, busy;
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 16; i++) begin
                orig[i] = 8'($urandom_range(0, 255));
                fwd[i]  = sbox_tbl[orig[i]];
            end
            send_block(fwd, lat, res, pulses, busy);
            n_cmp++;
            if (res !== orig || lat !== LAT) begin
                n_bad++;
                $display("FAIL round_trip_%0d: got %h lat %0d expected %h lat %0d",
                         n, res, lat, orig, LAT);
            end
        end
    endtask

    initial begin
        n_cmp            = 0;
        n_bad            = 0;
        rst              = 1'b1;
        bus.new_block_in = 1'b0;
        bus.block_in     = '0;
        build_sbox();
        test_reset();
        test_all_63();
        test_counting();
        test_mixed();
        test_ignore_new();
        test_mid_reset();
        test_back_to_back();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
